// File: rtl/cntr_universal.sv
// Parametrised universal counter: enable, clear, load, up/down, programmable
// terminal value, wrap/saturate, terminal-count pulse, sticky overflow, Gray copy.
module cntr_universal #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         up_dn,
    input  logic         sat,
    input  logic [N-1:0] max_val,
    output logic [N-1:0] cntr_out,
    output logic [N-1:0] gray_out,
    output logic         tc,
    output logic         ovf
);

    logic [N-1:0] cnt_nxt;
    logic         bnd_evt;

    // Boundary detection is by comparison against max_val, never by carry.
    always_comb begin
        cnt_nxt = cntr_out;
        bnd_evt = 1'b0;
        if (clr) begin
            cnt_nxt = '0;
        end else if (load) begin
            cnt_nxt = (load_val > max_val) ? max_val : load_val;
        end else if (en) begin
            if (up_dn) begin
                if (cntr_out < max_val) begin
                    cnt_nxt = cntr_out + 1'b1;
                end else begin
                    bnd_evt = 1'b1;
                    cnt_nxt = sat ? max_val : '0;
                end
            end else begin
                if (cntr_out > max_val) begin
                    cnt_nxt = max_val;
                end else if (cntr_out != '0) begin
                    cnt_nxt = cntr_out - 1'b1;
                end else begin
                    bnd_evt = 1'b1;
                    cnt_nxt = sat ? '0 : max_val;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cntr_out <= '0;
            gray_out <= '0;
            tc       <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            cntr_out <= cnt_nxt;
            gray_out <= cnt_nxt ^ (cnt_nxt >> 1);
            tc       <= bnd_evt;
            ovf      <= clr ? 1'b0 : (ovf | bnd_evt);
        end
    end

endmodule

// File: tb/tb_cntr_universal.sv
// Directed table-driven bench for cntr_universal at N=4.
module tb_cntr_universal;

    localparam int N = 4;

    logic         clk;
    logic         reset;
    logic         en;
    logic         clr;
    logic         load;
    logic [N-1:0] load_val;
    logic         up_dn;
    logic         sat;
    logic [N-1:0] max_val;
    logic [N-1:0] cntr_out;
    logic [N-1:0] gray_out;
    logic         tc;
    logic         ovf;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic         clr;
        logic         load;
        logic         en;
        logic         up_dn;
        logic         sat;
        logic [N-1:0] load_val;
        logic [N-1:0] max_val;
        logic [N-1:0] e_cnt;
        logic         e_tc;
        logic         e_ovf;
    } vec_t;

    vec_t vecs[$];

    cntr_universal #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .up_dn    (up_dn),
        .sat      (sat),
        .max_val  (max_val),
        .cntr_out (cntr_out),
        .gray_out (gray_out),
        .tc       (tc),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic c, input logic l, input logic e,
                                input logic u, input logic s,
                                input logic [N-1:0] lv, input logic [N-1:0] mv,
                                input logic [N-1:0] ec, input logic et, input logic eo);
        vec_t v;
        v.clr = c; v.load = l; v.en = e; v.up_dn = u; v.sat = s;
        v.load_val = lv; v.max_val = mv; v.e_cnt = ec; v.e_tc = et; v.e_ovf = eo;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic [N-1:0] ec, input logic et, input logic eo);
        logic [N-1:0] eg;
        eg = ec ^ (ec >> 1);
        chk("cntr_out", idx, 32'(cntr_out), 32'(ec));
        chk("gray_out", idx, 32'(gray_out), 32'(eg));
        chk("tc",       idx, 32'(tc),       32'(et));
        chk("ovf",      idx, 32'(ovf),      32'(eo));
    endtask

    task automatic drive(input vec_t v);
        clr = v.clr; load = v.load; en = v.en; up_dn = v.up_dn; sat = v.sat;
        load_val = v.load_val; max_val = v.max_val;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //              clr load en up sat lv     mv     cnt    tc ovf
        vecs.push_back(mk(1, 0, 0, 1, 0, 4'd0,  4'd15, 4'd0,  0, 0));
        // load then count down with wrap at max_val=9
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd3,  4'd9,  4'd3,  0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'd0,  4'd9,  4'd2,  0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'd0,  4'd9,  4'd1,  0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'd0,  4'd9,  4'd0,  0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'd0,  4'd9,  4'd9,  1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'd0,  4'd9,  4'd8,  0, 1));
        // load clamp, hold, clr beats load+en
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'd12, 4'd9,  4'd9,  0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'd0,  4'd9,  4'd9,  0, 1));
        vecs.push_back(mk(1, 1, 1, 1, 0, 4'd6,  4'd9,  4'd0,  0, 0));
        // saturate up at 5, then down to 0
        vecs.push_back(mk(0, 0, 1, 1, 1, 4'd0,  4'd5,  4'd1,  0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 4'd0,  4'd5,  4'd2,  0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 4'd0,  4'd5,  4'd3,  0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 4'd0,  4'd5,  4'd4,  0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 4'd0,  4'd5,  4'd5,  0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 4'd0,  4'd5,  4'd5,  1, 1));
        vecs.push_back(mk(0, 0, 1, 1, 1, 4'd0,  4'd5,  4'd5,  1, 1));
        vecs.push_back(mk(0, 0, 1, 1, 1, 4'd0,  4'd5,  4'd5,  1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 4'd0,  4'd5,  4'd4,  0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 4'd0,  4'd5,  4'd3,  0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 4'd0,  4'd5,  4'd2,  0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 4'd0,  4'd5,  4'd1,  0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 4'd0,  4'd5,  4'd0,  0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 4'd0,  4'd5,  4'd0,  1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 4'd0,  4'd5,  4'd0,  1, 1));
        // load+en at the boundary: load wins, no event
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'd9,  4'd9,  4'd9,  0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'd0,  4'd9,  4'd0,  1, 1));
        // max_val lowered below the count
        vecs.push_back(mk(1, 0, 0, 1, 0, 4'd0,  4'd15, 4'd0,  0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'd8,  4'd15, 4'd8,  0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'd0,  4'd4,  4'd0,  1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'd8,  4'd15, 4'd8,  0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'd0,  4'd4,  4'd4,  0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'd0,  4'd4,  4'd3,  0, 1));
        // max_val = 0: every enabled step is an event
        vecs.push_back(mk(1, 0, 0, 1, 0, 4'd0,  4'd0,  4'd0,  0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'd0,  4'd0,  4'd0,  1, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'd0,  4'd0,  4'd0,  1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'd0,  4'd0,  4'd0,  0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'd0,  4'd0,  4'd0,  1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'd7,  4'd15, 4'd7,  0, 1));

        reset = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0;
        load_val = '0; up_dn = 1'b1; sat = 1'b0; max_val = 4'd15;
        #12;
        chk_all(-1, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // free-running wrap over the full 4-bit range
        for (int i = 1; i <= 17; i++) begin
            drive(mk(0, 0, 1, 1, 0, 4'd0, 4'd15, 4'd0, 0, 0));
            chk_all(100 + i, 4'(i % 16), (i == 16), (i >= 16));
        end

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            chk_all(i, vecs[i].e_cnt, vecs[i].e_tc, vecs[i].e_ovf);
        end

        // async reset between edges with cnt=7, ovf=1
        #2;
        reset = 1'b0;
        #1;
        chk_all(200, 4'd0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        drive(mk(0, 0, 0, 1, 0, 4'd0, 4'd15, 4'd0, 0, 0));
        chk_all(201, 4'd0, 1'b0, 1'b0);
        drive(mk(0, 0, 1, 1, 0, 4'd0, 4'd15, 4'd0, 0, 0));
        chk_all(202, 4'd1, 1'b0, 1'b0);
        drive(mk(0, 0, 1, 1, 0, 4'd0, 4'd15, 4'd0, 0, 0));
        chk_all(203, 4'd2, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cntr_universal.md
# cntr_universal

Parametrised N-bit universal counter, the successor to the fixed free-running counter. It adds enable, synchronous clear, parallel load, up/down direction, a programmable terminal value, and wrap or saturate mode. It also provides a registered terminal-count pulse, a sticky overflow flag and a Gray-coded copy of the count. It serves as the general timing/sequence counter for the Registers_and_Counters blocks.

## Interface
- N, default 8: counter width in bits, N ≥ 2.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- en  input  1  count enable; one step per clock when high.
- clr  input  1  synchronous clear.
- load  input  1  synchronous parallel load.
- load_val  input  N  value for load.
- up_dn  input  1  1 = count up, 0 = count down.
- sat  input  1  1 = saturate at the boundary, 0 = wrap.
- max_val  input  N  terminal value; count range is 0..max_val.
- cntr_out  output  N  registered binary count.
- gray_out  output  N  registered Gray code of cntr_out (bin ^ (bin >> 1)), same cycle alignment.
- tc  output  1  registered one-cycle terminal-count pulse.
- ovf  output  1  sticky overflow/underflow flag.

## Operation
- Priority per rising edge: clr > load > en > hold.
- clr: cntr_out ← 0, ovf ← 0, tc ← 0.
- load: cntr_out ← min(load_val, max_val); tc ← 0; ovf unchanged.
- en, up (up_dn=1):
  - cnt < max_val: cnt+1.
  - cnt ≥ max_val: boundary event. Wrap mode gives 0; sat mode gives max_val.
- en, down (up_dn=0):
  - 0 < cnt ≤ max_val: cnt−1.
  - cnt > max_val: max_val, no event. This covers max_val lowered while running.
  - cnt = 0: boundary event. Wrap mode gives max_val; sat mode holds 0.
- Boundary event: tc ← 1 for exactly the next cycle; ovf ← 1 and stays set until clr or reset.
- No boundary event: tc ← 0.
- en=0 and no clr/load: all outputs hold, except tc ← 0.
- max_val = 0: count stays 0 and every enabled step is a boundary event, so tc is high continuously while en=1.
- Arithmetic is unsigned N-bit. No internal carry is exposed; the boundary test uses comparison, never an N+1-bit overflow.
- up_dn, sat and max_val may change on any cycle and take effect on the next edge.
- Implementation: one next-state block, with the result registered into cntr_out and gray_out. gray_out is computed from the next binary value so both outputs update on the same edge.

## Timing
- Reset (reset=0, asynchronous): cntr_out=0, gray_out=0, tc=0, ovf=0 immediately, independent of clk.
- Reset deassertion is assumed synchronous to clk upstream. The first count occurs on the first rising edge with reset=1 and en=1.
- Latency: 1 clock from an en/clr/load sample to the cntr_out/gray_out update.
- tc and ovf assert on the same edge that applies the boundary value, so they are aligned with the wrapped/saturated cntr_out.
- tc width is exactly 1 cycle per boundary event. Consecutive events (sat held at the boundary, or max_val=0) keep tc high.
- Reset mid-count aborts immediately to the reset values. No state survives reset.
- Simultaneous clr and load and en: clr wins. Simultaneous load and en: load wins, and no boundary event is generated.

## Test plan
- Reset/wrap (N=4, max_val=15, up, wrap, en=1 from reset release): cntr_out goes 0..15 then 0. tc is high only in the cycle cntr_out=0 after 15; ovf=1 from then on. gray_out matches 0,1,3,2,6,… each cycle.
- Modulus/down (max_val=9, up_dn=0, wrap, load 3): sequence 3,2,1,0,9,8. tc pulses with the 9.
- Saturate (max_val=5, sat=1): counts up to 5 and holds at 5 for 3 more cycles with tc high all 3 cycles. Then down_dn=0 counts to 0 and holds with tc high; ovf=1.
- Priority/clamp: load_val=12 with max_val=9 loads 9. clr+load+en in the same cycle gives 0 with ovf cleared. Load+en in the same cycle gives load_val with tc=0.
- Modulus change: cnt=8 with max_val dropped to 4. Up/wrap gives 0 with tc=1; down gives 4 with tc=0.
- Async reset: assert reset=0 between clock edges at cnt=7 with ovf=1. All outputs go 0 before the next edge, and counting resumes from 0 after release.
